sysarr_seq: RTL and testbench

Sequencer for the 4x4 floating-point systolic array `sysarr`. Holds operand matrices A and B in local buffers, written through a simple word port. On `start` it clears the array accumulators and streams A rows onto the left edge (`l*`) and B columns onto the top edge (`u*`) with the diagonal skew the array requires. It then waits out the pipeline drain and pulses `done` when `sysarr` results `r11..r44` are final. It sits between the host/register interface and `sysarr`, replacing hand-sequenced stimulus.

---
 rtl/sysarr_seq.sv | 146 ++++++++++++++
 tb/tb_sysarr_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sysarr_seq.sv
// Operand buffers and skewed feed sequencer for the 4x4 systolic array sysarr.
// A rows go out on l1..l4 and B columns on u1..u4, skewed one cycle per row/column.
module sysarr_seq #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int DRAIN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          arr_rst,
  output logic [DW-1:0] l1,
  output logic [DW-1:0] l2,
  output logic [DW-1:0] l3,
  output logic [DW-1:0] l4,
  output logic [DW-1:0] u1,
  output logic [DW-1:0] u2,
  output logic [DW-1:0] u3,
  output logic [DW-1:0] u4
);

  localparam int AW     = $clog2(N);
  localparam int LAST_T = 2*N - 2;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [DW-1:0] a_buf [N][N];
  logic [DW-1:0] b_buf [N][N];
  logic [DW-1:0] l_q [N];
  logic [DW-1:0] u_q [N];

  // Row i of A enters i cycles late; zero outside the row's window.
  function automatic logic [DW-1:0] a_feed(input int t, input int i);
    int k;
    k = t - i;
    if (k >= 0 && k < N) return a_buf[AW'(i)][AW'(k)];
    return '0;
  endfunction

  function automatic logic [DW-1:0] b_feed(input int t, input int j);
    int k;
    k = t - j;
    if (k >= 0 && k < N) return b_buf[AW'(k)][AW'(j)];
    return '0;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      arr_rst <= 1'b0;
      for (int r = 0; r < N; r++) begin
        l_q[r] <= '0;
        u_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else begin
      busy    <= 1'b0;
      done    <= 1'b0;
      arr_rst <= 1'b0;
      for (int r = 0; r < N; r++) begin
        l_q[r] <= '0;
        u_q[r] <= '0;
      end
      case (state)
        S_IDLE: begin
          if (wr_en) begin
            if (wr_sel) b_buf[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
            else        a_buf[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
          end
          if (start) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            arr_rst <= 1'b1;
          end
        end
        // Feeds are read from the buffers here, so a write on the start edge is included.
        S_CLEAR: begin
          state <= S_FEED;
          cnt   <= '0;
          busy  <= 1'b1;
          for (int r = 0; r < N; r++) begin
            l_q[r] <= a_feed(0, r);
            u_q[r] <= b_feed(0, r);
          end
        end
        S_FEED: begin
          busy <= 1'b1;
          if (cnt == 8'(LAST_T)) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
            for (int r = 0; r < N; r++) begin
              l_q[r] <= a_feed(int'(cnt) + 1, r);
              u_q[r] <= b_feed(int'(cnt) + 1, r);
            end
          end
        end
        S_DRAIN: begin
          if (cnt == 8'(DRAIN - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            busy <= 1'b1;
            cnt  <= cnt + 8'd1;
          end
        end
        // DONE also samples start so held-start runs repeat every 1+(2N-1)+DRAIN+1 cycles.
        S_DONE: begin
          if (start) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            arr_rst <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign l1 = l_q[0];
  assign l2 = l_q[1];
  assign l3 = l_q[2];
  assign l4 = l_q[3];
  assign u1 = u_q[0];
  assign u2 = u_q[1];
  assign u3 = u_q[2];
  assign u4 = u_q[3];

endmodule

// File: tb/tb_sysarr_seq.sv
// Scoreboard bench for sysarr_seq: each run pushes its expected per-cycle outputs,
// a negedge monitor pops one record per cycle (all-zero when nothing is queued).
module tb_sysarr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_sel, start;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, arr_rst;
  logic [31:0] l1, l2, l3, l4, u1, u2, u3, u4;

  sysarr_seq #(.N(4), .DW(32), .DRAIN(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .arr_rst(arr_rst),
    .l1(l1), .l2(l2), .l3(l3), .l4(l4), .u1(u1), .u2(u2), .u3(u3), .u4(u4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            arr_rst;
    logic            busy;
    logic            done;
    logic [3:0][31:0] l;
    logic [3:0][31:0] u;
  } rec_t;

  rec_t        q[$];
  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];
  logic [31:0] lo [4];
  logic [31:0] uo [4];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  assign lo[0] = l1; assign lo[1] = l2; assign lo[2] = l3; assign lo[3] = l4;
  assign uo[0] = u1; assign uo[1] = u2; assign uo[2] = u3; assign uo[3] = u4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_l(input int t, input int i);
    int k;
    k = t - i;
    return (k >= 0 && k < 4) ? ma[i][k] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_u(input int t, input int j);
    int k;
    k = t - j;
    return (k >= 0 && k < 4) ? mb[k][j] : 32'h0;
  endfunction

  // 13 cycles after the sampling edge: CLEAR, FEED x7, DRAIN x4, DONE.
  task automatic push_run();
    for (int k = 0; k < 13; k++) begin
      rec_t r;
      r = '0;
      if (k == 0) begin
        r.arr_rst = 1'b1;
        r.busy    = 1'b1;
      end else if (k <= 7) begin
        r.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
          r.l[i] = exp_l(k - 1, i);
          r.u[i] = exp_u(k - 1, i);
        end
      end else if (k <= 11) begin
        r.busy = 1'b1;
      end else begin
        r.done = 1'b1;
      end
      q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (mon_en) begin
      e = (q.size() != 0) ? q.pop_front() : '0;
      chk("arr_rst", {31'b0, arr_rst}, {31'b0, e.arr_rst});
      chk("busy",    {31'b0, busy},    {31'b0, e.busy});
      chk("done",    {31'b0, done},    {31'b0, e.done});
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("l%0d", i + 1), lo[i], e.l[i]);
        chk($sformatf("u%0d", i + 1), uo[i], e.u[i]);
      end
    end
  end

  task automatic wr(input bit sel, input int row, input int col, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = {row[1:0], col[1:0]};
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel) mb[row][col] = d;
    else     ma[row][col] = d;
  endtask

  task automatic start_run(input bit with_wr, input bit sel, input int row, input int col,
                           input logic [31:0] d);
    start = 1'b1;
    if (with_wr) begin
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = {row[1:0], col[1:0]};
      wr_data = d;
      if (sel) mb[row][col] = d;
      else     ma[row][col] = d;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    push_run();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 32'h0;
        mb[r][c] = 32'h0;
      end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    clear_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Identity matrices
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, i, 32'h3f800000);
      wr(1'b1, i, i, 32'h3f800000);
    end
    start_run(1'b0, 1'b0, 0, 0, 32'h0);
    wait_idle();

    // Skew pattern on every element
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        wr(1'b0, i, k, 32'h0000_0A00 + {i[1:0], k[1:0]});
        wr(1'b1, i, k, 32'h0000_0B00 + {i[1:0], k[1:0]});
      end
    start_run(1'b0, 1'b0, 0, 0, 32'h0);
    wait_idle();

    // start and a B write during FEED are ignored
    start_run(1'b0, 1'b0, 0, 0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'h0; wr_data = 32'h40000000;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_idle();
    start_run(1'b0, 1'b0, 0, 0, 32'h0);
    wait_idle();

    // Same-edge write and start
    start_run(1'b1, 1'b0, 0, 0, 32'h40400000);
    wait_idle();

    // Held start: back-to-back runs every 13 cycles
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      push_run();
      repeat (12) @(posedge clk);
      #1;
      if (r == 2) start = 1'b0;
    end
    wait_idle();

    // Reset during FEED t=3 aborts and clears buffers
    start_run(1'b0, 1'b0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    q.delete();
    clear_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_run(1'b0, 1'b0, 0, 0, 32'h0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
